// File: rtl/decoder_pkg.sv
// Shared types and helpers for the sequential one-hot decoder.
package decoder_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      SCAN   = 2'd2
   } state_e;

   // Widest decoded vector the helpers can produce; callers cast down to their width.
   localparam int unsigned MAX_W = 256;

   // Bit idx set when idx < width; all zeros otherwise.
   function automatic logic [MAX_W-1:0] onehot(input int unsigned idx, input int unsigned width);
      logic [MAX_W-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < MAX_W; i++) begin
         r[i] = (i == idx) && (i < width);
      end
      return r;
   endfunction

   // Applies output polarity: active-low inverts the whole vector, including the idle value.
   function automatic logic [MAX_W-1:0] polarity(input logic [MAX_W-1:0] v, input bit active_low);
      return active_low ? ~v : v;
   endfunction

endpackage

// File: rtl/onehot_decoder_seq_hold_timer.sv
// Counts 1..HOLD_CYCLES after start; done is high on the last hold cycle.
module hold_timer #(
   parameter int unsigned HOLD_CYCLES = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic clr,
   output logic done
);

   localparam int unsigned   CW   = $clog2(HOLD_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES);

   logic [CW-1:0] cnt_q, cnt_d;

   assign done = (cnt_q == LAST);

   // Next count: clear wins, start (re)loads 1, stop after the last cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (start) begin
         cnt_d = CW'(1);
      end else if (done) begin
         cnt_d = '0;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered one-hot decoder with valid/ready accept, programmable hold and auto-scan.
module onehot_decoder_seq
   import decoder_pkg::*;
#(
   parameter int unsigned SEL_W       = 2,
   parameter int unsigned HOLD_CYCLES = 1,
   parameter bit          ACTIVE_LOW  = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  mode,
   input  logic                  sel_valid,
   input  logic [SEL_W-1:0]      sel,
   output logic                  sel_ready,
   output logic [2**SEL_W-1:0]   y,
   output logic                  y_valid,
   output logic                  scan_wrap
);

   localparam int unsigned      OUT_W = 2**SEL_W;
   localparam logic [OUT_W-1:0] INACT = OUT_W'(polarity('0, ACTIVE_LOW));
   localparam logic [OUT_W-1:0] SCAN0 = OUT_W'(polarity(onehot(0, OUT_W), ACTIVE_LOW));

   state_e           state_q;
   logic [SEL_W-1:0] index_q, index_d;
   logic [OUT_W-1:0] y_q;
   logic             y_valid_q, scan_wrap_q;
   logic             accept, start, clr, done;
   logic [OUT_W-1:0] sel_line, next_line;

   assign sel_ready = (state_q == IDLE) & en & ~mode;
   assign accept    = sel_valid & sel_ready;
   assign index_d   = index_q + 1'b1;
   assign clr       = ~en;
   assign start     = en & (((state_q == IDLE) & (accept | mode)) |
                            ((state_q == SCAN) & done & mode));

   // Candidate line patterns, polarity applied before they reach the output flop.
   always_comb begin
      sel_line  = OUT_W'(polarity(onehot(32'(sel), OUT_W), ACTIVE_LOW));
      next_line = OUT_W'(polarity(onehot(32'(index_d), OUT_W), ACTIVE_LOW));
   end

   hold_timer #(
      .HOLD_CYCLES (HOLD_CYCLES)
   ) u_hold (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .clr   (clr),
      .done  (done)
   );

   // Control FSM with registered outputs; en low forces idle from any state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         y_q         <= INACT;
         y_valid_q   <= 1'b0;
         scan_wrap_q <= 1'b0;
         index_q     <= '0;
      end else if (!en) begin
         state_q     <= IDLE;
         y_q         <= INACT;
         y_valid_q   <= 1'b0;
         scan_wrap_q <= 1'b0;
         index_q     <= '0;
      end else begin
         scan_wrap_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_q   <= DECODE;
                  y_q       <= sel_line;
                  y_valid_q <= 1'b1;
               end else if (mode) begin
                  state_q   <= SCAN;
                  index_q   <= '0;
                  y_q       <= SCAN0;
                  y_valid_q <= 1'b1;
               end
            end
            DECODE: begin
               if (done) begin
                  state_q   <= IDLE;
                  y_q       <= INACT;
                  y_valid_q <= 1'b0;
               end
            end
            SCAN: begin
               if (done) begin
                  if (mode) begin
                     index_q     <= index_d;
                     y_q         <= next_line;
                     scan_wrap_q <= (index_q == '1);
                  end else begin
                     state_q   <= IDLE;
                     index_q   <= '0;
                     y_q       <= INACT;
                     y_valid_q <= 1'b0;
                  end
               end
            end
            default: begin
               state_q   <= IDLE;
               index_q   <= '0;
               y_q       <= INACT;
               y_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign y         = y_q;
   assign y_valid   = y_valid_q;
   assign scan_wrap = scan_wrap_q;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Directed checks of the one-hot decoder across four parameter sets plus a random invariant run.
module tb_onehot_decoder_seq;

   logic clk = 1'b0;
   logic rst_n, rst4_n;
   int unsigned n_chk = 0;
   int unsigned n_bad = 0;

   // u1: SEL_W=2, HOLD=1
   logic en1, mode1, v1, r1, yv1, w1;
   logic [1:0] s1;
   logic [3:0] y1;
   // u2: SEL_W=3, HOLD=3
   logic en2, mode2, v2, r2, yv2, w2;
   logic [2:0] s2;
   logic [7:0] y2;
   // u3: SEL_W=2, HOLD=2
   logic en3, mode3, v3, r3, yv3, w3;
   logic [1:0] s3;
   logic [3:0] y3;
   // u4: SEL_W=2, HOLD=2, active-low
   logic en4, mode4, v4, r4, yv4, w4;
   logic [1:0] s4;
   logic [3:0] y4;

   logic [3:0] exp1 [6]  = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2};
   logic       wr1  [6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
   logic [3:0] exp3 [11] = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h1, 4'h2};
   logic       wr3  [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

   always #5 clk = ~clk;

   onehot_decoder_seq #(.SEL_W(2), .HOLD_CYCLES(1), .ACTIVE_LOW(1'b0)) u1 (
      .clk(clk), .rst_n(rst_n), .en(en1), .mode(mode1), .sel_valid(v1), .sel(s1),
      .sel_ready(r1), .y(y1), .y_valid(yv1), .scan_wrap(w1));
   onehot_decoder_seq #(.SEL_W(3), .HOLD_CYCLES(3), .ACTIVE_LOW(1'b0)) u2 (
      .clk(clk), .rst_n(rst_n), .en(en2), .mode(mode2), .sel_valid(v2), .sel(s2),
      .sel_ready(r2), .y(y2), .y_valid(yv2), .scan_wrap(w2));
   onehot_decoder_seq #(.SEL_W(2), .HOLD_CYCLES(2), .ACTIVE_LOW(1'b0)) u3 (
      .clk(clk), .rst_n(rst_n), .en(en3), .mode(mode3), .sel_valid(v3), .sel(s3),
      .sel_ready(r3), .y(y3), .y_valid(yv3), .scan_wrap(w3));
   onehot_decoder_seq #(.SEL_W(2), .HOLD_CYCLES(2), .ACTIVE_LOW(1'b1)) u4 (
      .clk(clk), .rst_n(rst4_n), .en(en4), .mode(mode4), .sel_valid(v4), .sel(s4),
      .sel_ready(r4), .y(y4), .y_valid(yv4), .scan_wrap(w4));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; rst4_n = 1'b0;
      en1 = 1'b1; mode1 = 1'b0; v1 = 1'b0; s1 = '0;
      en2 = 1'b1; mode2 = 1'b0; v2 = 1'b0; s2 = '0;
      en3 = 1'b1; mode3 = 1'b0; v3 = 1'b0; s3 = '0;
      en4 = 1'b1; mode4 = 1'b0; v4 = 1'b0; s4 = '0;
      #12;
      chk("rst_y1", y1, 4'h0);
      chk("rst_yv1", yv1, 0);
      chk("rst_w1", w1, 0);
      chk("rst_y4_al", y4, 4'hF);
      chk("rst_yv4", yv4, 0);
      rst_n = 1'b1; rst4_n = 1'b1;
      tick();
      chk("idle_y1", y1, 4'h0);
      chk("idle_rdy1", r1, 1);

      // T1: HOLD=1 decode, then back-to-back grants with one idle gap
      s1 = 2'd2; v1 = 1'b1; #1;
      chk("t1_rdy", r1, 1);
      tick(); v1 = 1'b0;
      chk("t1_y", y1, 4'b0100);
      chk("t1_yv", yv1, 1);
      chk("t1_busy", r1, 0);
      tick();
      chk("t1_back_y", y1, 4'h0);
      chk("t1_back_yv", yv1, 0);
      chk("t1_back_rdy", r1, 1);
      s1 = 2'd3; v1 = 1'b1;
      tick(); s1 = 2'd1;
      chk("b2b_y0", y1, 4'b1000);
      tick();
      chk("b2b_gap", y1, 4'h0);
      chk("b2b_gap_rdy", r1, 1);
      tick(); v1 = 1'b0;
      chk("b2b_y1", y1, 4'b0010);
      tick();
      chk("b2b_end", y1, 4'h0);

      // HOLD=1 scan advances every cycle
      mode1 = 1'b1; #1;
      chk("scan1_rdy", r1, 0);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("scan1_y%0d", i), y1, exp1[i]);
         chk($sformatf("scan1_w%0d", i), w1, wr1[i]);
      end
      en1 = 1'b0; #1;
      chk("dis1_rdy", r1, 0);
      tick();
      chk("dis1_y", y1, 4'h0);
      chk("dis1_yv", yv1, 0);
      chk("dis1_w", w1, 0);
      en1 = 1'b1; mode1 = 1'b0;

      // T2: HOLD=3, sel ignored while busy
      s2 = 3'd5; v2 = 1'b1;
      tick(); s2 = 3'd1;
      chk("t2_y_a", y2, 8'h20);
      chk("t2_rdy_a", r2, 0);
      tick();
      chk("t2_y_b", y2, 8'h20);
      chk("t2_rdy_b", r2, 0);
      tick(); v2 = 1'b0;
      chk("t2_y_c", y2, 8'h20);
      chk("t2_rdy_c", r2, 0);
      tick();
      chk("t2_y_end", y2, 8'h00);
      chk("t2_yv_end", yv2, 0);
      chk("t2_rdy_end", r2, 1);

      // en dropped mid-hold aborts, then a fresh grant gets a full hold
      s2 = 3'd7; v2 = 1'b1;
      tick(); v2 = 1'b0;
      chk("t2_abort_a", y2, 8'h80);
      tick();
      chk("t2_abort_b", y2, 8'h80);
      en2 = 1'b0;
      tick();
      chk("t2_abort_y", y2, 8'h00);
      chk("t2_abort_yv", yv2, 0);
      en2 = 1'b1;
      tick();
      chk("t2_reidle", y2, 8'h00);
      s2 = 3'd0; v2 = 1'b1;
      tick(); v2 = 1'b0;
      chk("t2_fresh_a", y2, 8'h01);
      tick();
      chk("t2_fresh_b", y2, 8'h01);
      tick();
      chk("t2_fresh_c", y2, 8'h01);
      tick();
      chk("t2_fresh_end", y2, 8'h00);

      // T3: HOLD=2 scan with wrap pulse
      mode3 = 1'b1;
      for (int i = 0; i < 11; i++) begin
         tick();
         chk($sformatf("t3_y%0d", i), y3, exp3[i]);
         chk($sformatf("t3_w%0d", i), w3, wr3[i]);
      end
      // T4: mode dropped mid-slot finishes the slot
      mode3 = 1'b0; #1;
      chk("t4_rdy_mid", r3, 0);
      tick();
      chk("t4_slot_y", y3, 4'b0010);
      chk("t4_slot_yv", yv3, 1);
      tick();
      chk("t4_idle_y", y3, 4'h0);
      chk("t4_idle_yv", yv3, 0);
      chk("t4_idle_rdy", r3, 1);
      mode3 = 1'b1;
      tick();
      chk("t4_rescan", y3, 4'b0001);
      en3 = 1'b0;
      tick();
      chk("t4_en_y", y3, 4'h0);
      chk("t4_en_yv", yv3, 0);
      en3 = 1'b1; mode3 = 1'b0;

      // T5: active-low outputs and asynchronous reset mid-decode
      s4 = 2'd0; v4 = 1'b1;
      tick(); v4 = 1'b0;
      chk("t5_y", y4, 4'b1110);
      chk("t5_yv", yv4, 1);
      #2 rst4_n = 1'b0;
      #1;
      chk("t5_async_y", y4, 4'hF);
      chk("t5_async_yv", yv4, 0);
      #2 rst4_n = 1'b1;
      tick();
      chk("t5_post_y", y4, 4'hF);
      mode4 = 1'b1;
      tick();
      chk("t5_scan_a", y4, 4'b1110);
      tick();
      chk("t5_scan_b", y4, 4'b1110);
      tick();
      chk("t5_scan_c", y4, 4'b1101);

      // T6: random stimulus, output invariants every cycle
      for (int i = 0; i < 1000; i++) begin
         en3   = ($urandom_range(0, 15) != 0);
         mode3 = 1'($urandom_range(0, 1));
         v3    = 1'($urandom_range(0, 1));
         s3    = 2'($urandom_range(0, 3));
         tick();
         chk("rand_onehot", yv3 ? $onehot(y3) : (y3 == 4'h0), 1);
         chk("rand_wrap", !w3 || (y3 == 4'b0001), 1);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
